// File: rtl/instr_mem_loader.sv
// Framed byte-stream loader for the 16-bit instruction RAM: length header, data words,
// optional NOP fill of the remaining addresses, core held in reset while loading.
module instr_mem_loader #(
    parameter int          DEPTH     = 101,
    parameter int          ADDR_W    = 32,
    parameter logic [15:0] FILL_WORD = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_fill_en,
    input  logic [7:0]        i_byte,
    input  logic              i_byte_valid,
    output logic              o_byte_ready,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [15:0]       o_wdata,
    output logic              o_busy,
    output logic              o_cpu_hold,
    output logic              o_done,
    output logic              o_loaded,
    output logic              o_err
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LEN_HI  = 4'd1,
        S_LEN_LO  = 4'd2,
        S_DATA_HI = 4'd3,
        S_DATA_LO = 4'd4,
        S_FILL    = 4'd5,
        S_DONE    = 4'd6,
        S_ERR     = 4'd7
    } state_t;

    localparam logic [15:0] DEPTH_W = 16'(DEPTH);
    localparam logic [15:0] LAST_W  = 16'(DEPTH - 1);

    state_t      state_r, state_s;
    logic [15:0] cnt_r, len_r;
    logic [7:0]  hi_r;
    logic        fill_en_r;
    logic        accept_s, restart_s;
    logic [15:0] cnt_inc_s, len_full_s;

    logic              byte_ready_r, we_r, busy_r, done_r, loaded_r, err_r;
    logic [ADDR_W-1:0] waddr_r;
    logic [15:0]       wdata_r;
    logic              ready_s, we_s, busy_s, done_s, loaded_s, err_s;
    logic [15:0]       wdata_s;

    assign accept_s   = i_byte_valid && byte_ready_r;
    assign restart_s  = i_start && ((state_r == S_IDLE) || (state_r == S_DONE) || (state_r == S_ERR));
    assign cnt_inc_s  = cnt_r + 16'd1;
    assign len_full_s = {len_r[15:8], i_byte};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:    if (restart_s) state_s = S_LEN_HI; else state_s = S_IDLE;
            S_LEN_HI:  if (accept_s) state_s = S_LEN_LO; else state_s = S_LEN_HI;
            S_LEN_LO: begin
                if (!accept_s)                 state_s = S_LEN_LO;
                else if (len_full_s > DEPTH_W) state_s = S_ERR;
                else if (len_full_s == 16'd0)  state_s = fill_en_r ? S_FILL : S_DONE;
                else                           state_s = S_DATA_HI;
            end
            S_DATA_HI: if (accept_s) state_s = S_DATA_LO; else state_s = S_DATA_HI;
            S_DATA_LO: begin
                if (!accept_s)                                state_s = S_DATA_LO;
                else if (cnt_inc_s < len_r)                   state_s = S_DATA_HI;
                else if (fill_en_r && (cnt_inc_s < DEPTH_W))  state_s = S_FILL;
                else                                          state_s = S_DONE;
            end
            S_FILL:    if (cnt_r == LAST_W) state_s = S_DONE; else state_s = S_FILL;
            S_DONE:    if (restart_s) state_s = S_LEN_HI; else state_s = S_IDLE;
            S_ERR:     if (restart_s) state_s = S_LEN_HI; else state_s = S_ERR;
            default:   state_s = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, derived from the upcoming state
    always_comb begin
        we_s    = ((state_r == S_DATA_LO) && accept_s) || (state_r == S_FILL);
        wdata_s = {hi_r, i_byte};
        if (state_r == S_FILL) begin
            wdata_s = FILL_WORD;
        end else begin
            wdata_s = {hi_r, i_byte};
        end
        ready_s = (state_s == S_LEN_HI) || (state_s == S_LEN_LO) ||
                  (state_s == S_DATA_HI) || (state_s == S_DATA_LO);
        busy_s  = !((state_s == S_IDLE) || (state_s == S_ERR) || (state_s == S_DONE));
        done_s  = (state_s == S_DONE);
        err_s   = (state_s == S_ERR);
        loaded_s = loaded_r;
        if (restart_s) begin
            loaded_s = 1'b0;
        end else if (state_s == S_DONE) begin
            loaded_s = 1'b1;
        end else begin
            loaded_s = loaded_r;
        end
    end

    // Datapath: frame latches, word counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r        <= 16'd0;
            len_r        <= 16'd0;
            hi_r         <= 8'd0;
            fill_en_r    <= 1'b0;
            byte_ready_r <= 1'b0;
            we_r         <= 1'b0;
            waddr_r      <= '0;
            wdata_r      <= 16'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            loaded_r     <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            if (restart_s) begin
                fill_en_r <= i_fill_en;
                cnt_r     <= 16'd0;
            end else if (we_s) begin
                cnt_r <= cnt_inc_s;
            end
            if ((state_r == S_LEN_HI) && accept_s) len_r[15:8] <= i_byte;
            if ((state_r == S_LEN_LO) && accept_s) len_r[7:0]  <= i_byte;
            if ((state_r == S_DATA_HI) && accept_s) hi_r <= i_byte;
            if (we_s) begin
                waddr_r <= ADDR_W'(cnt_r);
                wdata_r <= wdata_s;
            end
            we_r         <= we_s;
            byte_ready_r <= ready_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            loaded_r     <= loaded_s;
            err_r        <= err_s;
        end
    end

    assign o_byte_ready = byte_ready_r;
    assign o_we         = we_r;
    assign o_waddr      = waddr_r;
    assign o_wdata      = wdata_r;
    assign o_busy       = busy_r;
    assign o_cpu_hold   = busy_r;
    assign o_done       = done_r;
    assign o_loaded     = loaded_r;
    assign o_err        = err_r;

endmodule
